// File: rtl/cpu_apb_bridge_pkg.sv
// Shared definitions for the CPU-to-APB bridge: the bus widths, the FSM state
// encoding, the APB direction constant and the saturating wait-counter increment.
package cpu_apb_bridge_pkg;

    localparam int ADDR_WIDTH     = 32;
    localparam int APB_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    localparam logic APB_RW_WRITE = 1'b1;

    // Wait counter increment that sticks at all-ones instead of wrapping
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/cpu_apb_bridge_if.sv
// Bundles the CPU request/response port and the CPU-side APB decoder port.
// The bridge uses the master modport; the CPU and decoder models use slave.
interface cpu_apb_bridge_if;
    import cpu_apb_bridge_pkg::*;

    logic                      cpu_req;
    logic                      cpu_wr;
    logic [ADDR_WIDTH-1:0]     cpu_addr;
    logic [APB_DATA_WIDTH-1:0] cpu_wdata;
    logic                      cpu_ready;
    logic                      cpu_rvalid;
    logic [APB_DATA_WIDTH-1:0] cpu_rdata;
    logic                      cpu_err;

    logic                      apb_psel;
    logic                      apb_rw;
    logic [ADDR_WIDTH-1:0]     apb_addr;
    logic                      apb_enab;
    logic [APB_DATA_WIDTH-1:0] apb_datai;
    logic [APB_DATA_WIDTH-1:0] apb_datao;
    logic                      apb_ack;

    modport master (
        input  cpu_req, cpu_wr, cpu_addr, cpu_wdata, apb_datao, apb_ack,
        output cpu_ready, cpu_rvalid, cpu_rdata, cpu_err,
               apb_psel, apb_rw, apb_addr, apb_enab, apb_datai
    );

    modport slave (
        output cpu_req, cpu_wr, cpu_addr, cpu_wdata, apb_datao, apb_ack,
        input  cpu_ready, cpu_rvalid, cpu_rdata, cpu_err,
               apb_psel, apb_rw, apb_addr, apb_enab, apb_datai
    );

endinterface

// File: rtl/cpu_apb_bridge.sv
// Converts one CPU load/store at a time into an APB SETUP/ACCESS transfer,
// waits for the slave ack and returns read data, or an error if the slave
// stays silent for TIMEOUT_CYCLES wait cycles (0 = wait forever).
// Every output is a flop or a decode of the state register.
module cpu_apb_bridge
    import cpu_apb_bridge_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic          clk,
    input  logic          rst,
    cpu_apb_bridge_if.master bus
);

    localparam logic [15:0] TIMEOUT_W  = TIMEOUT_CYCLES[15:0];
    localparam bit          TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

    state_t                    state_q, state_d;
    logic [15:0]               cnt_q, cnt_d;
    logic                      rw_q, rw_d;
    logic [ADDR_WIDTH-1:0]     addr_q, addr_d;
    logic [APB_DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [APB_DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                      err_q, err_d;

    // Next-state logic: latch the request, run SETUP/ACCESS, pick ack vs timeout
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rw_d    = rw_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.cpu_req) begin
                    rw_d    = bus.cpu_wr;
                    addr_d  = bus.cpu_addr;
                    wdata_d = bus.cpu_wdata;
                    cnt_d   = 16'd0;
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                state_d = ST_ACCESS;
            end
            ST_ACCESS: begin
                // Ack takes priority over a timeout reached in the same cycle
                if (bus.apb_ack) begin
                    rdata_d = (rw_q == APB_RW_WRITE) ? '0 : bus.apb_datao;
                    err_d   = 1'b0;
                    state_d = ST_RESP;
                end else if (TIMEOUT_EN && (cnt_q >= TIMEOUT_W)) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = sat_inc16(cnt_q);
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset clears everything so a transfer cut
    // short by reset leaves no trace on the bus
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            rw_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rw_q    <= rw_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign bus.cpu_ready  = (state_q == ST_IDLE);
    assign bus.cpu_rvalid = (state_q == ST_RESP);
    assign bus.cpu_rdata  = rdata_q;
    assign bus.cpu_err    = err_q;
    assign bus.apb_psel   = (state_q == ST_SETUP) || (state_q == ST_ACCESS);
    assign bus.apb_enab   = (state_q == ST_ACCESS);
    assign bus.apb_rw     = rw_q;
    assign bus.apb_addr   = addr_q;
    assign bus.apb_datai  = wdata_q;

endmodule

// File: doc/cpu_apb_bridge.md
# cpu_apb_bridge

APB master front-end that converts single CPU load/store requests into APB transfers. It drives the CPU-side port of the 9-slave APB decoder: `apb_psel_cpu`, `apb_rw_cpu`, `apb_addr_cpu`, `apb_enab_cpu` and `apb_datai_cpu`, and it consumes `apb_datao_cpu` and `apb_ack_cpu`. It runs the SETUP/ACCESS sequence, waits for the slave ack and returns read data or an error to the CPU. A bounded wait timer prevents a hung peripheral from stalling the core.

## Interface
Parameters:
- TIMEOUT_CYCLES, 255, number of ACCESS cycles without ack before abort; 0 disables timeout; legal range 0..65535
- Widths come from `` `ADDR_WIDTH `` (32) and `` `APB_DATA_WIDTH `` (32) in config.v

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- cpu_req  in  1  request valid; must hold until accepted
- cpu_wr  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_WIDTH  byte address
- cpu_wdata  in  APB_DATA_WIDTH  write data
- cpu_ready  out  1  request accepted this cycle (cpu_req & cpu_ready)
- cpu_rvalid  out  1  one-cycle response pulse
- cpu_rdata  out  APB_DATA_WIDTH  read data, valid with cpu_rvalid
- cpu_err  out  1  timeout flag, valid with cpu_rvalid
- apb_psel  out  1  to apb_psel_cpu
- apb_rw  out  1  to apb_rw_cpu, 1 = write
- apb_addr  out  ADDR_WIDTH  to apb_addr_cpu
- apb_enab  out  1  to apb_enab_cpu
- apb_datai  out  APB_DATA_WIDTH  to apb_datai_cpu
- apb_datao  in  APB_DATA_WIDTH  from apb_datao_cpu
- apb_ack  in  1  from apb_ack_cpu

## Operation
- FSM states: IDLE, SETUP, ACCESS, RESP.
- **IDLE:** cpu_ready = 1.
  - On cpu_req, register cpu_wr, cpu_addr and cpu_wdata into apb_rw, apb_addr and apb_datai, then go to SETUP.
- **SETUP:** apb_psel = 1, apb_enab = 0. Always go to ACCESS next.
- **ACCESS:** apb_psel = 1, apb_enab = 1. Sample apb_ack every cycle.
  - ack = 1: capture apb_datao into cpu_rdata (reads only; on writes cpu_rdata is 0), set cpu_err = 0, go to RESP.
  - ack = 0: increment the 16-bit wait counter.
  - Counter reaches TIMEOUT_CYCLES (and TIMEOUT_CYCLES ≠ 0): abort. Set cpu_rdata = 0, cpu_err = 1, go to RESP.
  - ack and timeout in the same cycle: ack wins, cpu_err = 0.
- **RESP:** cpu_rvalid = 1 for exactly one cycle. psel = enab = 0. Return to IDLE.
- cpu_ready is 0 in SETUP, ACCESS and RESP. Requests are never queued; cpu_req held during a transfer is accepted on the next IDLE.
- apb_addr, apb_rw and apb_datai stay constant from SETUP through the end of ACCESS. They hold their last value in IDLE and RESP.
- The wait counter clears on entry to SETUP. It saturates and never wraps.
- Unmapped addresses: the decoder returns ack = 1 with data 0. This completes normally with rdata = 0 and err = 0.
- **Reset values:** state = IDLE, cpu_ready = 1 in the first cycle after reset. All other outputs and registers are 0.
- **Reset mid-transfer:** next cycle is IDLE with psel = enab = 0. No cpu_rvalid is produced for the aborted transfer.

## Timing
- Request accepted at the end of cycle N. SETUP in N+1. ACCESS in N+2 and later.
- With ack in the first ACCESS cycle: cpu_rvalid in N+3, cpu_ready again in N+4. Back-to-back throughput is 4 cycles per transfer.
- Each wait cycle adds 1 cycle of latency. A timeout fires in ACCESS cycle TIMEOUT_CYCLES+1, and cpu_rvalid follows one cycle later.
- All outputs are registered or decoded directly from state. There is no combinational path from apb_ack or apb_datao to any output.

## Structure
- Shared package/include holds the state encoding (2-bit: IDLE = 0, SETUP = 1, ACCESS = 2, RESP = 3) and APB_RW_WRITE = 1.
- Widths stay in config.v (`` `ADDR_WIDTH ``, `` `APB_DATA_WIDTH ``).
- Single module, no sub-module. The saturating wait counter is inline.

## Test plan
- Read 0x1FE00010 with ack in the first ACCESS cycle and slave data 0xA5A5_5A5A -> psel high in N+1/N+2, enab high in N+2 only; cpu_rvalid in N+3 with rdata 0xA5A5_5A5A, err = 0.
- Write 0x1FE00020 data 0x1234_5678 with ack delayed 3 cycles -> addr, rw = 1 and datai stable across SETUP plus 4 ACCESS cycles; cpu_rvalid in N+6, rdata = 0, err = 0.
- TIMEOUT_CYCLES = 4 with ack stuck low -> 5 ACCESS cycles, then psel = enab = 0, cpu_rvalid with err = 1 and rdata = 0; the next request proceeds normally.
- Ack asserted in the same cycle the timeout is reached -> err = 0, data captured.
- cpu_req held continuously for two transfers -> cpu_ready only in IDLE; second SETUP begins 4 cycles after the first; no overlap of psel.
- rst asserted during ACCESS -> next cycle state IDLE, psel = enab = 0, cpu_ready = 1; no cpu_rvalid pulse.
